// File: rtl/aiken2421_rx_monitor.sv
// Receive-side checker/decoder for a 2421 (Aiken) decade-count stream.
// Decodes each qualified word to BCD, tracks sequence lock and accumulates a tens digit.
module aiken2421_rx_monitor #(
  parameter int LOCK_N     = 3,
  parameter int ALLOW_HOLD = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_vld,
  input  logic [3:0]       code_in,
  output logic [3:0]       bcd,
  output logic             bcd_vld,
  output logic [3:0]       tens,
  output logic             locked,
  output logic             invalid,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: code_vld qualifies code_in for one cycle; there is no backpressure.
  // Each qualified word yields exactly one bcd_vld or invalid pulse one cycle later.
  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0]       LOCK_C  = 4'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [3:0]       r_ref;
  logic [3:0]       r_good;
  logic [3:0]       r_bcd;
  logic             r_bcd_vld;
  logic [3:0]       r_tens;
  logic             r_locked;
  logic             r_invalid;
  logic             r_seq_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic       w_valid;
  logic [3:0] w_d;
  logic [3:0] w_next;
  logic       w_good_step;
  logic       w_wrap;
  logic [3:0] w_good_inc;

  always_comb begin
    w_valid = 1'b1;
    w_d     = 4'd0;
    case (code_in)
      4'b0000: w_d = 4'd0;
      4'b0001: w_d = 4'd1;
      4'b0010: w_d = 4'd2;
      4'b0011: w_d = 4'd3;
      4'b0100: w_d = 4'd4;
      4'b1011: w_d = 4'd5;
      4'b1100: w_d = 4'd6;
      4'b1101: w_d = 4'd7;
      4'b1110: w_d = 4'd8;
      4'b1111: w_d = 4'd9;
      default: w_valid = 1'b0;
    endcase
  end

  assign w_next      = (r_ref == 4'd9) ? 4'd0 : r_ref + 4'd1;
  assign w_good_step = (w_d == w_next) || ((ALLOW_HOLD != 0) && (w_d == r_ref));
  assign w_wrap      = (r_ref == 4'd9) && (w_d == 4'd0);
  assign w_good_inc  = r_good + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= HUNT;
      r_ref     <= 4'd0;
      r_good    <= 4'd0;
      r_bcd     <= 4'd0;
      r_bcd_vld <= 1'b0;
      r_tens    <= 4'd0;
      r_locked  <= 1'b0;
      r_invalid <= 1'b0;
      r_seq_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_bcd_vld <= 1'b0;
      r_invalid <= 1'b0;
      r_seq_err <= 1'b0;
      if (code_vld) begin
        if (!w_valid) begin
          // Invalid words leave ref/bcd untouched so the last good value stays visible.
          r_invalid <= 1'b1;
          r_state   <= HUNT;
          r_good    <= 4'd0;
          r_locked  <= 1'b0;
          if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_ONE;
        end else begin
          r_ref     <= w_d;
          r_bcd     <= w_d;
          r_bcd_vld <= 1'b1;
          case (r_state)
            HUNT: begin
              r_state  <= CHECK;
              r_good   <= 4'd0;
              r_locked <= 1'b0;
            end
            CHECK: begin
              if (w_good_step) begin
                r_good <= w_good_inc;
                if (w_good_inc >= LOCK_C) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
                end
              end else begin
                r_seq_err <= 1'b1;
                r_good    <= 4'd0;
                if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_ONE;
              end
            end
            LOCKED: begin
              if (w_good_step) begin
                if (w_wrap) r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
              end else begin
                r_seq_err <= 1'b1;
                r_good    <= 4'd0;
                r_state   <= CHECK;
                r_locked  <= 1'b0;
                if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_ONE;
              end
            end
            default: begin
              r_state  <= HUNT;
              r_good   <= 4'd0;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bcd       = r_bcd;
  assign bcd_vld   = r_bcd_vld;
  assign tens      = r_tens;
  assign locked    = r_locked;
  assign invalid   = r_invalid;
  assign seq_err   = r_seq_err;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule
